// File: rtl/ysyx_24100029_ifu_pkg.sv
// ysyx_24100029_ifu_pkg: shared state encoding and line geometry for the instruction fetch unit.
package ysyx_24100029_ifu_pkg;
    typedef enum logic [1:0] {REQ, WAIT, SERVE} ifu_state_e;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_BITS = 27;
endpackage

// File: rtl/ysyx_24100029_ifu_wordsel.sv
// ysyx_24100029_ifu_wordsel: combinational selection of one 32-bit word out of a cache line.
module ysyx_24100029_ifu_wordsel
    import ysyx_24100029_ifu_pkg::*;
#(
    parameter int LINE_WIDTH = 256
) (
    input  logic [LINE_WIDTH-1:0]                 line,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]     sel,
    output logic [31:0]                           word
);
    assign word = line[32*sel +: 32];
endmodule

// File: rtl/ysyx_24100029_ifu.sv
// ysyx_24100029_ifu: owns the PC, fetches lines from the icache, buffers one line and
// streams one instruction per cycle to decode; handles redirects and fence.i.
module ysyx_24100029_ifu
    import ysyx_24100029_ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    LINE_WIDTH = 256,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  fence_i,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_arvalid,
    input  logic                  ic_arready,
    output logic                  ic_rready,
    input  logic [LINE_WIDTH-1:0] ic_line,
    input  logic                  ic_rvalid,
    output logic                  ic_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [31:0]           out_inst
);
    ifu_state_e            state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, tgt;
    logic [LINE_WIDTH-1:0] lbuf;
    logic [TAG_BITS-1:0]   ltag;
    logic                  lvalid, lvalid_n, discard, discard_n;
    logic                  clr_pend, clr_pend_n, clr, clr_n, capture, tgt_hit;

    assign tgt        = redirect_pc & ~ADDR_WIDTH'(3);
    assign tgt_hit    = lvalid && ltag == tgt[ADDR_WIDTH-1:OFFSET_BITS];
    assign ic_addr    = {pc[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
    // The clr cycle holds off the next request so invalidation lands first.
    assign ic_arvalid = reset && state == REQ && !clr;
    assign ic_rready  = state == WAIT;
    assign ic_clr     = clr;
    assign out_valid  = state == SERVE;
    assign out_pc     = pc;

    ysyx_24100029_ifu_wordsel #(.LINE_WIDTH(LINE_WIDTH)) u_wordsel (
        .line (lbuf),
        .sel  (pc[4:2]),
        .word (out_inst)
    );

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        lvalid_n   = lvalid;
        discard_n  = discard;
        clr_pend_n = clr_pend;
        clr_n      = 1'b0;
        capture    = 1'b0;
        case (state)
            REQ:   if (ic_arvalid && ic_arready) state_n = WAIT;
            WAIT:  if (ic_rvalid) begin
                state_n    = discard ? REQ : SERVE;
                capture    = !discard;
                lvalid_n   = lvalid || !discard;
                discard_n  = 1'b0;
                clr_n      = clr_pend;
                clr_pend_n = 1'b0;
            end
            SERVE: if (out_ready) begin
                pc_n    = pc + ADDR_WIDTH'(4);
                state_n = &pc[4:2] ? REQ : SERVE;
            end
            default: state_n = REQ;
        endcase
        // An issued request is always completed; a redirect only poisons its data.
        if (redirect_valid) begin
            pc_n = tgt;
            if (state_n == WAIT) discard_n = 1'b1;
            else state_n = (state == SERVE && tgt_hit) ? SERVE : REQ;
        end
        if (fence_i) begin
            lvalid_n = 1'b0;
            if (state_n == WAIT) begin
                discard_n  = 1'b1;
                clr_pend_n = 1'b1;
            end else begin
                clr_n   = 1'b1;
                state_n = REQ;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            lbuf     <= '0;
            ltag     <= '0;
            lvalid   <= 1'b0;
            discard  <= 1'b0;
            clr_pend <= 1'b0;
            clr      <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            lvalid   <= lvalid_n;
            discard  <= discard_n;
            clr_pend <= clr_pend_n;
            clr      <= clr_n;
            if (capture) begin
                lbuf <= ic_line;
                ltag <= pc[ADDR_WIDTH-1:OFFSET_BITS];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// tb_ysyx_24100029_ifu: directed bench with a simple icache responder model.
module tb_ysyx_24100029_ifu;
    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         fence_i;
    logic [31:0]  ic_addr;
    logic         ic_arvalid;
    logic         ic_arready;
    logic         ic_rready;
    logic [255:0] ic_line;
    logic         ic_rvalid;
    logic         ic_clr;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_inst;

    int n_cmp = 0;
    int n_err = 0;
    int lat = 2;
    int reqs = 0;

    ysyx_24100029_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i        (fence_i),
        .ic_addr        (ic_addr),
        .ic_arvalid     (ic_arvalid),
        .ic_arready     (ic_arready),
        .ic_rready      (ic_rready),
        .ic_line        (ic_line),
        .ic_rvalid      (ic_rvalid),
        .ic_clr         (ic_clr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[21:0], 10'b0} + 32'h13;
    endfunction

    function automatic logic [255:0] line_for(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = inst_of(base + 32'(4*k));
        return l;
    endfunction

    // Icache model: always ready for requests, answers lat cycles after the handshake.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        ic_arready = 1'b1;
        ic_rvalid = 1'b0;
        ic_line = '0;
        forever begin
            @(negedge clock);
            ic_rvalid = 1'b0;
            if (!reset) pend = 1'b0;
            else if (pend) begin
                if (cnt == 0) begin
                    ic_rvalid = 1'b1;
                    ic_line = line_for(paddr);
                    pend = 1'b0;
                end else cnt--;
            end else if (ic_arvalid) begin
                pend = 1'b1;
                paddr = ic_addr;
                cnt = lat;
                reqs++;
            end
        end
    end

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clock);
        if (!out_valid) begin n_cmp++; n_err++; $display("FAIL %s: out_valid got 0 want 1 (timeout)", tag); end
    endtask

    task automatic wait_arvalid(input string tag);
        for (int i = 0; i < 40 && !ic_arvalid; i++) @(negedge clock);
        if (!ic_arvalid) begin n_cmp++; n_err++; $display("FAIL %s: ic_arvalid got 0 want 1 (timeout)", tag); end
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        @(negedge clock);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fence_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++; if ({ic_arvalid, ic_rready, ic_clr, out_valid} !== 4'b0000) begin n_err++; $display("FAIL reset ctrl: got %b want 0000", {ic_arvalid, ic_rready, ic_clr, out_valid}); end
        n_cmp++; if (ic_addr !== 32'h8000_0000 || out_pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset addr: got %h/%h want 80000000", ic_addr, out_pc); end
        n_cmp++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset inst: got %h want 0", out_inst); end
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0000) begin n_err++; $display("FAIL first req: got %b/%h want 1/80000000", ic_arvalid, ic_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        out_ready = 1'b1;
        wait_valid("stream");
        for (int i = 0; i < 8; i++) begin
            p = 32'h8000_0000 + 32'(4*i);
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== p) begin n_err++; $display("FAIL stream pc[%0d]: got %b/%h want 1/%h", i, out_valid, out_pc, p); end
            n_cmp++; if (out_inst !== inst_of(p)) begin n_err++; $display("FAIL stream inst[%0d]: got %h want %h", i, out_inst, inst_of(p)); end
            @(negedge clock);
        end
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0020) begin n_err++; $display("FAIL stream next req: got %b/%h want 1/80000020", ic_arvalid, ic_addr); end
    endtask

    task automatic test_stall();
        int r0;
        out_ready = 1'b0;
        wait_valid("stall");
        r0 = reqs;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0020 || out_inst !== inst_of(32'h8000_0020)) begin n_err++; $display("FAIL stall hold[%0d]: got %b/%h/%h want 1/80000020/%h", i, out_valid, out_pc, out_inst, inst_of(32'h8000_0020)); end
            n_cmp++; if (ic_arvalid !== 1'b0) begin n_err++; $display("FAIL stall arvalid[%0d]: got %b want 0", i, ic_arvalid); end
            @(negedge clock);
        end
        n_cmp++; if (reqs !== r0) begin n_err++; $display("FAIL stall reqs: got %0d want %0d", reqs, r0); end
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++; if (out_pc !== 32'h8000_0024) begin n_err++; $display("FAIL stall resume: got %h want 80000024", out_pc); end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        int r0;
        redirect_to(32'h8000_0004);
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0000) begin n_err++; $display("FAIL redir miss req: got %b/%h want 1/80000000", ic_arvalid, ic_addr); end
        wait_valid("redir 04");
        n_cmp++; if (out_pc !== 32'h8000_0004) begin n_err++; $display("FAIL redir 04 pc: got %h want 80000004", out_pc); end
        r0 = reqs;
        out_ready = 1'b1;
        redirect_to(32'h8000_0013);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0010 || out_inst !== inst_of(32'h8000_0010)) begin n_err++; $display("FAIL redir hit: got %b/%h/%h want 1/80000010/%h", out_valid, out_pc, out_inst, inst_of(32'h8000_0010)); end
        n_cmp++; if (ic_arvalid !== 1'b0 || reqs !== r0) begin n_err++; $display("FAIL redir hit req: got %b/%0d want 0/%0d", ic_arvalid, reqs, r0); end
        redirect_to(32'h8000_0080);
        n_cmp++; if (out_valid !== 1'b0 || ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0080) begin n_err++; $display("FAIL redir 80 req: got %b/%b/%h want 0/1/80000080", out_valid, ic_arvalid, ic_addr); end
        out_ready = 1'b0;
        wait_valid("redir 80");
        n_cmp++; if (out_pc !== 32'h8000_0080 || out_inst !== inst_of(32'h8000_0080)) begin n_err++; $display("FAIL redir 80 pc: got %h/%h want 80000080/%h", out_pc, out_inst, inst_of(32'h8000_0080)); end
    endtask

    task automatic test_redirect_wait();
        lat = 4;
        out_ready = 1'b1;
        redirect_to(32'h8000_0100);
        @(negedge clock);
        n_cmp++; if (ic_rready !== 1'b1) begin n_err++; $display("FAIL rwait in WAIT: got rready %b want 1", ic_rready); end
        redirect_to(32'h8000_0208);
        n_cmp++; if (ic_rready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rwait hold: got %b/%b want 1/0", ic_rready, out_valid); end
        wait_arvalid("rwait");
        n_cmp++; if (ic_addr !== 32'h8000_0200 || out_valid !== 1'b0) begin n_err++; $display("FAIL rwait req: got %h/%b want 80000200/0", ic_addr, out_valid); end
        wait_valid("rwait");
        n_cmp++; if (out_pc !== 32'h8000_0208 || out_inst !== inst_of(32'h8000_0208)) begin n_err++; $display("FAIL rwait pc: got %h/%h want 80000208/%h", out_pc, out_inst, inst_of(32'h8000_0208)); end
        out_ready = 1'b0;
        lat = 2;
    endtask

    task automatic test_fence();
        redirect_to(32'h8000_0300);
        wait_valid("fence");
        fence_i = 1'b1;
        @(negedge clock);
        fence_i = 1'b0;
        n_cmp++; if ({ic_clr, ic_arvalid, out_valid} !== 3'b100) begin n_err++; $display("FAIL fence pulse: got %b want 100", {ic_clr, ic_arvalid, out_valid}); end
        @(negedge clock);
        n_cmp++; if (ic_clr !== 1'b0 || ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0300) begin n_err++; $display("FAIL fence rereq: got %b/%b/%h want 0/1/80000300", ic_clr, ic_arvalid, ic_addr); end
        wait_valid("fence");
        n_cmp++; if (out_pc !== 32'h8000_0300) begin n_err++; $display("FAIL fence pc: got %h want 80000300", out_pc); end
    endtask

    task automatic test_fence_wait();
        int nclr;
        nclr = 0;
        lat = 3;
        redirect_to(32'h8000_0400);
        @(negedge clock);
        fence_i = 1'b1;
        @(negedge clock);
        fence_i = 1'b0;
        for (int i = 0; i < 20 && !ic_arvalid; i++) begin
            if (ic_clr) nclr++;
            @(negedge clock);
        end
        n_cmp++; if (nclr !== 1) begin n_err++; $display("FAIL fwait clr cycles: got %0d want 1", nclr); end
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_clr !== 1'b0 || ic_addr !== 32'h8000_0400) begin n_err++; $display("FAIL fwait rereq: got %b/%b/%h want 1/0/80000400", ic_arvalid, ic_clr, ic_addr); end
        wait_valid("fwait");
        n_cmp++; if (out_pc !== 32'h8000_0400) begin n_err++; $display("FAIL fwait pc: got %h want 80000400", out_pc); end
        lat = 2;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFF8);
        wait_valid("wrap");
        n_cmp++; if (out_pc !== 32'hFFFF_FFF8 || out_inst !== inst_of(32'hFFFF_FFF8)) begin n_err++; $display("FAIL wrap f8: got %h/%h want fffffff8/%h", out_pc, out_inst, inst_of(32'hFFFF_FFF8)); end
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++; if (out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap fc: got %h want fffffffc", out_pc); end
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_addr !== 32'h0) begin n_err++; $display("FAIL wrap req: got %b/%h want 1/00000000", ic_arvalid, ic_addr); end
        wait_valid("wrap");
        n_cmp++; if (out_pc !== 32'h0 || out_inst !== 32'h13) begin n_err++; $display("FAIL wrap zero: got %h/%h want 00000000/00000013", out_pc, out_inst); end
    endtask

    task automatic test_reset_mid();
        lat = 10;
        redirect_to(32'h8000_0500);
        @(negedge clock);
        n_cmp++; if (ic_rready !== 1'b1) begin n_err++; $display("FAIL rmid in WAIT: got rready %b want 1", ic_rready); end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({ic_arvalid, ic_rready, ic_clr, out_valid} !== 4'b0000) begin n_err++; $display("FAIL rmid ctrl: got %b want 0000", {ic_arvalid, ic_rready, ic_clr, out_valid}); end
        n_cmp++; if (ic_addr !== 32'h8000_0000 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0) begin n_err++; $display("FAIL rmid regs: got %h/%h/%h want 80000000/80000000/0", ic_addr, out_pc, out_inst); end
        lat = 2;
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (ic_arvalid !== 1'b1 || ic_addr !== 32'h8000_0000) begin n_err++; $display("FAIL rmid req: got %b/%h want 1/80000000", ic_arvalid, ic_addr); end
        wait_valid("rmid");
        n_cmp++; if (out_pc !== 32'h8000_0000 || out_inst !== 32'h13) begin n_err++; $display("FAIL rmid pc: got %h/%h want 80000000/00000013", out_pc, out_inst); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_wait();
        test_fence();
        test_fence_wait();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
